// File: rtl/wave_voice_mux_if.sv
// Bus bundle for wave_voice_mux: sample strobe, channel/table configuration
// writes and the mixed sample output.
interface wave_voice_mux_if #(
    parameter int CHANNELS = 4,
    parameter int TABLES   = 4,
    parameter int TABLE_AW = 6,
    parameter int SAMPLE_W = 16,
    parameter int PHASE_W  = 24,
    parameter int VOL_W    = 8
);
    localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int WSEL_W = (TABLES > 1) ? $clog2(TABLES) : 1;

    logic                       tick;
    logic                       cfg_we;
    logic [CH_W-1:0]            cfg_ch;
    logic [PHASE_W-1:0]         cfg_freq;
    logic [WSEL_W-1:0]          cfg_wave;
    logic [VOL_W-1:0]           cfg_vol;
    logic                       cfg_key;
    logic                       tbl_we;
    logic [WSEL_W+TABLE_AW-1:0] tbl_addr;
    logic [SAMPLE_W-1:0]        tbl_data;
    logic [SAMPLE_W-1:0]        sample_o;
    logic                       sample_valid;
    logic                       busy;

    modport master (
        output tick, cfg_we, cfg_ch, cfg_freq, cfg_wave, cfg_vol, cfg_key,
        output tbl_we, tbl_addr, tbl_data,
        input  sample_o, sample_valid, busy
    );

    modport slave (
        input  tick, cfg_we, cfg_ch, cfg_freq, cfg_wave, cfg_vol, cfg_key,
        input  tbl_we, tbl_addr, tbl_data,
        output sample_o, sample_valid, busy
    );
endinterface

// File: rtl/wave_voice_mux.sv
// Time-multiplexed wavetable voice block: CHANNELS phase-accumulator oscillators
// swept one after another per tick, volume-scaled, summed and saturated.
module wave_voice_mux #(
    parameter int CHANNELS = 4,
    parameter int TABLES   = 4,
    parameter int TABLE_AW = 6,
    parameter int SAMPLE_W = 16,
    parameter int PHASE_W  = 24,
    parameter int VOL_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    wave_voice_mux_if.slave   bus
);
    localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int WSEL_W = (TABLES > 1) ? $clog2(TABLES) : 1;
    localparam int ADDR_W = WSEL_W + TABLE_AW;
    localparam int ACC_W  = SAMPLE_W + CH_W + 1;
    localparam int PROD_W = SAMPLE_W + VOL_W + 1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_ACC, S_OUT} state_t;

    state_t              r_state, w_stateNext;
    logic [CH_W-1:0]     r_ch, w_chNext;
    logic                w_start, w_accEn;

    logic [PHASE_W-1:0]  r_freq  [CHANNELS];
    logic [PHASE_W-1:0]  r_phase [CHANNELS];
    logic [WSEL_W-1:0]   r_wave  [CHANNELS];
    logic [VOL_W-1:0]    r_vol   [CHANNELS];
    logic [CHANNELS-1:0] r_key;

    logic [SAMPLE_W-1:0] r_tbl [2**ADDR_W];
    logic [SAMPLE_W-1:0] r_tblQ;
    logic [ADDR_W-1:0]   w_rdAddr;

    logic signed [ACC_W-1:0]  r_acc;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_contrib;
    logic [SAMPLE_W-1:0]      w_sat;
    logic [SAMPLE_W-1:0]      r_sample;
    logic                     r_valid;

    assign w_rdAddr = {r_wave[r_ch], r_phase[r_ch][PHASE_W-1 -: TABLE_AW]};

    // Table RAM has no reset; the registered read makes a same-edge write read-first.
    always_ff @(posedge clk) begin
        if (bus.tbl_we) r_tbl[bus.tbl_addr] <= bus.tbl_data;
        r_tblQ <= r_tbl[w_rdAddr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ch    <= '0;
        end else begin
            r_state <= w_stateNext;
            r_ch    <= w_chNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_chNext    = r_ch;
        w_start     = 1'b0;
        w_accEn     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.tick) begin
                    w_stateNext = S_RD;
                    w_chNext    = '0;
                    w_start     = 1'b1;
                end
            end
            S_RD: w_stateNext = S_ACC;
            S_ACC: begin
                w_accEn = 1'b1;
                if (r_ch == LAST_CH) begin
                    w_stateNext = S_OUT;
                end else begin
                    w_stateNext = S_RD;
                    w_chNext    = r_ch + 1'b1;
                end
            end
            S_OUT: w_stateNext = S_IDLE;
            default: w_stateNext = S_IDLE;
        endcase
    end

    // Volume is treated as unsigned by prepending a zero sign bit.
    assign w_prod    = PROD_W'($signed(r_tblQ)) * PROD_W'($signed({1'b0, r_vol[r_ch]}));
    assign w_contrib = ACC_W'(w_prod >>> VOL_W);

    always_comb begin
        w_sat = r_acc[SAMPLE_W-1:0];
        if (r_acc[ACC_W-1:SAMPLE_W-1] != {(ACC_W-SAMPLE_W+1){r_acc[ACC_W-1]}})
            w_sat = r_acc[ACC_W-1] ? {1'b1, {(SAMPLE_W-1){1'b0}}}
                                   : {1'b0, {(SAMPLE_W-1){1'b1}}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_sample <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= (r_state == S_OUT);
            if (w_start)
                r_acc <= '0;
            else if (w_accEn && r_key[r_ch])
                r_acc <= r_acc + w_contrib;
            if (r_state == S_OUT)
                r_sample <= w_sat;
        end
    end

    // A config write landing on a channel's ACC cycle wins; only a key-on clear overrides the advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_freq[i]  <= '0;
                r_phase[i] <= '0;
                r_wave[i]  <= '0;
                r_vol[i]   <= '0;
            end
            r_key <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (bus.cfg_we && bus.cfg_ch == CH_W'(i)) begin
                    r_freq[i] <= bus.cfg_freq;
                    r_wave[i] <= bus.cfg_wave;
                    r_vol[i]  <= bus.cfg_vol;
                    r_key[i]  <= bus.cfg_key;
                end
                if (bus.cfg_we && bus.cfg_ch == CH_W'(i) && bus.cfg_key && !r_key[i])
                    r_phase[i] <= '0;
                else if (w_accEn && r_ch == CH_W'(i) && r_key[i])
                    r_phase[i] <= r_phase[i] + r_freq[i];
            end
        end
    end

    assign bus.sample_o     = r_sample;
    assign bus.sample_valid = r_valid;
    assign bus.busy         = (r_state != S_IDLE);
endmodule

// File: tb/tb_wave_voice_mux.sv
// Bench for wave_voice_mux: directed sweeps with literal expected samples, then
// randomized traffic compared each cycle against a per-sweep arithmetic model.
module tb_wave_voice_mux;
    localparam int CH    = 4;
    localparam int SWEEP = 2 * CH + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nChecks = 0;
    int   nFail   = 0;

    wave_voice_mux_if ifc ();
    wave_voice_mux dut (.clk(clk), .rst(rst), .bus(ifc));

    always #5 clk = ~clk;

    logic signed [15:0] mTbl [256];
    logic [23:0] mFreq  [CH];
    logic [23:0] mPhase [CH];
    logic [1:0]  mWave  [CH];
    logic [7:0]  mVol   [CH];
    logic        mKey   [CH];
    int          mCyc = 0;
    logic [15:0] mPending = '0;
    logic        expValid = 1'b0;
    logic [15:0] expSample = '0;
    logic        modelLive = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        nChecks++;
        if (got !== want) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // One whole sweep: sum of floor(entry*vol/256) over keyed channels, clamped to 16 bits.
    function automatic logic [15:0] sweepModel();
        int acc;
        logic signed [15:0] e;
        acc = 0;
        for (int c = 0; c < CH; c++) begin
            if (mKey[c]) begin
                e = mTbl[{mWave[c], mPhase[c][23:18]}];
                acc += (int'(e) * int'(mVol[c])) >>> 8;
                mPhase[c] = mPhase[c] + mFreq[c];
            end
        end
        if (acc > 32767) acc = 32767;
        else if (acc < -32768) acc = -32768;
        return acc[15:0];
    endfunction

    always @(posedge clk) begin
        if (ifc.tbl_we) mTbl[ifc.tbl_addr] = ifc.tbl_data;
        if (rst) begin
            for (int c = 0; c < CH; c++) begin
                mFreq[c] = '0; mPhase[c] = '0; mWave[c] = '0; mVol[c] = '0; mKey[c] = 1'b0;
            end
            mCyc = 0; expValid = 1'b0; expSample = '0; modelLive = 1'b1;
        end else begin
            expValid = 1'b0;
            if (ifc.cfg_we) begin
                if (ifc.cfg_key && !mKey[ifc.cfg_ch]) mPhase[ifc.cfg_ch] = '0;
                mFreq[ifc.cfg_ch] = ifc.cfg_freq;
                mWave[ifc.cfg_ch] = ifc.cfg_wave;
                mVol[ifc.cfg_ch]  = ifc.cfg_vol;
                mKey[ifc.cfg_ch]  = ifc.cfg_key;
            end
            if (mCyc == 0) begin
                if (ifc.tick) begin
                    mPending = sweepModel();
                    mCyc = 1;
                end
            end else begin
                mCyc++;
                if (mCyc == SWEEP) begin
                    expValid = 1'b1; expSample = mPending; mCyc = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (modelLive) begin
            checkOutput("busy", ifc.busy, mCyc != 0);
            checkOutput("sample_valid", ifc.sample_valid, expValid);
            checkOutput("sample_o", ifc.sample_o, expSample);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfgWrite(input int ch, input logic [23:0] f, input int w, input int v, input logic k);
        ifc.cfg_we = 1'b1; ifc.cfg_ch = 2'(ch); ifc.cfg_freq = f;
        ifc.cfg_wave = 2'(w); ifc.cfg_vol = 8'(v); ifc.cfg_key = k;
        step();
        ifc.cfg_we = 1'b0;
    endtask

    task automatic tblWrite(input int a, input logic [15:0] d);
        ifc.tbl_we = 1'b1; ifc.tbl_addr = 8'(a); ifc.tbl_data = d;
        step();
        ifc.tbl_we = 1'b0;
    endtask

    task automatic tickOnce();
        ifc.tick = 1'b1;
        step();
        ifc.tick = 1'b0;
    endtask

    task automatic waitValid(input string name, output int cycles);
        cycles = 0;
        while (!ifc.sample_valid && cycles < 40) begin
            step();
            cycles++;
        end
        checkOutput({name, "_valid"}, ifc.sample_valid, 1'b1);
    endtask

    // One tick, then the produced sample and its latency against literal values.
    task automatic applyStimulus(input string name, input logic [15:0] want);
        int c;
        tickOnce();
        waitValid(name, c);
        checkOutput(name, ifc.sample_o, want);
        checkOutput({name, "_lat"}, c, SWEEP - 1);
    endtask

    initial begin
        int nValid, validCyc, r;
        ifc.tick = 0; ifc.cfg_we = 0; ifc.cfg_ch = 0; ifc.cfg_freq = 0; ifc.cfg_wave = 0;
        ifc.cfg_vol = 0; ifc.cfg_key = 0; ifc.tbl_we = 0; ifc.tbl_addr = 0; ifc.tbl_data = 0;
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        checkOutput("reset_busy", ifc.busy, 1'b0);
        checkOutput("reset_valid", ifc.sample_valid, 1'b0);
        checkOutput("reset_sample", ifc.sample_o, 16'h0000);

        for (int a = 0; a < 256; a++) tblWrite(a, (a < 64) ? 16'(a * 256) : 16'($urandom));

        cfgWrite(0, 24'h040000, 0, 255, 1'b1);
        applyStimulus("ramp0", 16'd0);
        applyStimulus("ramp1", 16'd255);
        applyStimulus("ramp2", 16'd510);
        applyStimulus("ramp3", 16'd765);

        cfgWrite(0, 24'hFC0000, 0, 255, 1'b0);
        cfgWrite(0, 24'hFC0000, 0, 255, 1'b1);
        applyStimulus("wrap0", 16'd0);
        applyStimulus("wrap63", 16'd16065);
        applyStimulus("wrap62", 16'd15810);
        applyStimulus("wrap61", 16'd15555);

        cfgWrite(0, 24'h040000, 0, 255, 1'b0);
        applyStimulus("keyoff", 16'd0);
        cfgWrite(0, 24'h040000, 0, 255, 1'b1);
        applyStimulus("keyon0", 16'd0);
        applyStimulus("keyon1", 16'd255);

        tickOnce();
        nValid = 0; validCyc = 0;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            if (ifc.sample_valid) begin nValid++; validCyc = cyc; end
            if (cyc == 9)  checkOutput("lat_busy9", ifc.busy, 1'b1);
            if (cyc == 10) checkOutput("lat_busy10", ifc.busy, 1'b0);
            if (cyc == 3) ifc.tick = 1'b1;
            step();
            ifc.tick = 1'b0;
        end
        checkOutput("lat_nvalid", nValid, 1);
        checkOutput("lat_cycle", validCyc, 10);

        tickOnce();
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("midrst_sample", ifc.sample_o, 16'h0000);
        checkOutput("midrst_busy", ifc.busy, 1'b0);
        nValid = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (ifc.sample_valid) nValid++;
            step();
        end
        checkOutput("midrst_novalid", nValid, 0);
        cfgWrite(0, 24'h040000, 0, 255, 1'b1);
        applyStimulus("postrst0", 16'd0);
        applyStimulus("postrst1", 16'd255);

        for (int t = 0; t < CH; t++) begin
            tblWrite(t * 64, 16'h7FFF);
            cfgWrite(t, 24'h0, t, 255, 1'b0);
            cfgWrite(t, 24'h0, t, 255, 1'b1);
        end
        applyStimulus("sat_pos", 16'h7FFF);
        for (int t = 0; t < CH; t++) tblWrite(t * 64, 16'h8000);
        applyStimulus("sat_neg", 16'h8000);

        for (int a = 0; a < 256; a++) tblWrite(a, 16'($urandom));
        for (int n = 0; n < 1500; n++) begin
            r = $urandom_range(0, 19);
            if (r < 3)
                tickOnce();
            else if (r < 6 && mCyc == 0)
                cfgWrite($urandom_range(0, 3), 24'($urandom), $urandom_range(0, 3),
                         $urandom_range(0, 255), $urandom_range(0, 3) != 0);
            else if (r == 6 && mCyc == 0)
                tblWrite($urandom_range(0, 255), 16'($urandom));
            else if (r == 7 && $urandom_range(0, 30) == 0) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
            end else
                step();
        end
        repeat (25) step();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
